// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned DEF_N_MASTER = 3;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TIMEOUT  = 16;
  localparam int unsigned MAX_MASTER   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot_idx(input logic [MAX_MASTER-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_MASTER); i++) begin
      if (v[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap-around.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDX_W'((32'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between N_MASTER masters,
// with per-cycle grant hold and an optional stall timeout that aborts with ERR.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTER = DEF_N_MASTER,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rstn_i,
  input  logic [N_MASTER-1:0]          m_cyc_i,
  input  logic [N_MASTER-1:0]          m_stb_i,
  input  logic [N_MASTER-1:0]          m_we_i,
  input  logic [N_MASTER*ADDR_W-1:0]   m_adr_i,
  input  logic [N_MASTER*DATA_W-1:0]   m_dat_i,
  input  logic [N_MASTER*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic [N_MASTER-1:0]          m_ack_o,
  output logic [N_MASTER-1:0]          m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  input  logic [DATA_W-1:0]            s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [N_MASTER-1:0]          grant_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(N_MASTER);

  arb_state_e          state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d, owner_idx;
  logic [N_MASTER-1:0] pick_gnt;
  logic                pick_valid;
  logic                busy, tmo_hit;

  logic                own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0]   own_adr;
  logic [DATA_W-1:0]   own_dat;
  logic [SEL_W-1:0]    own_sel;

  rr_pick #(.N(N_MASTER), .IDX_W(IDX_W)) u_pick (
    .req   (m_cyc_i),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Owner's bus signals, selected by the one-hot grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      if (grant_q[k]) begin
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_we  = m_we_i[k];
        own_adr = m_adr_i[k*ADDR_W +: ADDR_W];
        own_dat = m_dat_i[k*DATA_W +: DATA_W];
        own_sel = m_sel_i[k*SEL_W +: SEL_W];
      end
    end
  end

  assign owner_idx = IDX_W'(onehot_idx(MAX_MASTER'(grant_q)));
  assign busy      = (state_q == BUSY);

  // Stall counter: the abort fires on the cycle the count already equals TIMEOUT,
  // so a response arriving in that cycle still wins.
  if (TIMEOUT > 0) begin : g_tmo
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    assign stall   = busy && own_cyc && own_stb && !s_ack_i && !s_err_i;
    assign tmo_hit = stall && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
      cnt_d = '0;
      if (stall && !tmo_hit) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          grant_d = '0;
          last_d  = owner_idx;
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          grant_d = '0;
          last_d  = owner_idx;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Slave side is driven only while the owner holds the bus and no abort is firing.
  assign s_cyc_o = busy && own_cyc && !tmo_hit;
  assign s_stb_o = s_cyc_o && own_stb;
  assign s_we_o  = s_cyc_o && own_we;
  assign s_adr_o = s_cyc_o ? own_adr : '0;
  assign s_dat_o = s_cyc_o ? own_dat : '0;
  assign s_sel_o = s_cyc_o ? own_sel : '0;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = busy ? (grant_q & {N_MASTER{s_ack_i}}) : '0;
  assign m_err_o = busy ? (grant_q & {N_MASTER{s_err_i || tmo_hit}}) : '0;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: grant order, bursts, timeout abort, reset, fairness.
module tb_wb_rr_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rstn_i  (rstn),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .grant_o (grant_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input int k, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    m_adr = '0;
    m_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_dat = '0;
    tick();
    tick();
    rstn = 1'b1;
    settle();
  endtask

  initial begin
    m_sel = '1;
    do_reset();

    // Reset state
    s_dat = 32'h1234_5678;
    settle();
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_ack",   64'(m_ack_o), 64'd0);
    chk("rst_err",   64'(m_err_o), 64'd0);
    chk("rst_dat",   64'(m_dat_o), 64'h1234_5678);

    // Test 1: master 1 single read, ACK after 2 wait cycles
    drv(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    settle();
    chk("t1_idle_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    chk("t1_cyc",   64'(s_cyc_o), 64'd1);
    chk("t1_grant", 64'(grant_o), 64'b010);
    chk("t1_adr",   64'(s_adr_o), 64'h40);
    chk("t1_we",    64'(s_we_o),  64'd0);
    tick();
    tick();
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    settle();
    chk("t1_ack", 64'(m_ack_o), 64'b010);
    chk("t1_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    tick();
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    settle();
    chk("t1_drop_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    chk("t1_grant_idle", 64'(grant_o), 64'd0);

    // Test 2: all three request from reset, one write each
    do_reset();
    for (int k = 0; k < 3; k++) drv(k, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(k*4), 32'hA0 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      tick();
      s_ack = 1'b1;
      settle();
      chk($sformatf("t2_grant%0d", k), 64'(grant_o), 64'(1 << k));
      chk($sformatf("t2_ack%0d", k),   64'(m_ack_o), 64'(1 << k));
      chk($sformatf("t2_we%0d", k),    64'(s_we_o),  64'd1);
      tick();
      drv(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      s_ack = 1'b0;
      tick();
      chk($sformatf("t2_idle%0d", k), 64'(grant_o), 64'd0);
    end

    // Test 3: 4-beat burst by master 0 while master 2 waits
    do_reset();
    drv(2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    drv(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hB0);
    tick();
    for (int b = 0; b < 4; b++) begin
      m_adr[0 +: AW] = 32'(b * 4);
      s_ack = 1'b1;
      settle();
      chk($sformatf("t3_adr%0d", b), 64'(s_adr_o), 64'(b * 4));
      chk($sformatf("t3_ack%0d", b), 64'(m_ack_o), 64'b001);
      tick();
    end
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    settle();
    chk("t3_ack_after", 64'(m_ack_o), 64'd0);
    chk("t3_grant_hold", 64'(grant_o), 64'b001);
    tick();
    chk("t3_idle", 64'(grant_o), 64'd0);
    tick();
    chk("t3_grant2", 64'(grant_o), 64'b100);
    chk("t3_adr2",   64'(s_adr_o), 64'h200);

    // Test 4: slave never answers master 1 -> timeout abort
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (s_stb_o === 1'b1 && m_err_o === 3'b000) n++;
      tick();
    end
    chk("t4_stb_cycles", 64'(n), 64'd16);
    chk("t4_err",     64'(m_err_o), 64'b010);
    chk("t4_cyc_abt", 64'(s_cyc_o), 64'd0);
    tick();
    chk("t4_err_pulse", 64'(m_err_o), 64'd0);
    s_ack = 1'b1;
    settle();
    chk("t4_late_ack", 64'(m_ack_o), 64'd0);
    chk("t4_abort_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    s_ack = 1'b0;
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t4_idle", 64'(grant_o), 64'd0);

    // Test 5: asynchronous reset during master 2's transfer
    do_reset();
    drv(2, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    chk("t5_cyc",   64'(s_cyc_o), 64'd1);
    chk("t5_grant", 64'(grant_o), 64'b100);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_async_cyc",   64'(s_cyc_o), 64'd0);
    chk("t5_async_grant", 64'(grant_o), 64'd0);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    settle();
    chk("t5_idle", 64'(grant_o), 64'd0);
    tick();
    chk("t5_first", 64'(grant_o), 64'b001);

    // Test 6: fairness when master 0 re-requests immediately; then ACK+ERR together
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    tick();
    s_ack = 1'b1;
    settle();
    chk("t6_ack0", 64'(m_ack_o), 64'b001);
    tick();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    tick();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h28, 32'h0);
    settle();
    chk("t6_idle", 64'(grant_o), 64'd0);
    tick();
    chk("t6_fair", 64'(grant_o), 64'b010);
    s_ack = 1'b1;
    s_err = 1'b1;
    settle();
    chk("t6_both_ack", 64'(m_ack_o), 64'b010);
    chk("t6_both_err", 64'(m_err_o), 64'b010);
    s_ack = 1'b0;
    s_err = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone arbiter that shares one Wishbone slave port, such as the on-chip RAM, between N_MASTER requesters (debug module, core MEM stage, core IF stage).
- Grants the bus per Wishbone cycle and holds the grant for as long as the owner's CYC stays high.
- Aborts a stalled transfer with ERR once a programmable timeout expires.
- Sits between the masters and a single-slave region, in place of a full crossbar.

Parameters:
N_MASTER, 3, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; SEL width = DATA_W/8
TIMEOUT, 16, cycles an STB may wait for ACK/ERR before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
m_cyc_i  in  N_MASTER  per-master CYC
m_stb_i  in  N_MASTER  per-master STB
m_we_i  in  N_MASTER  per-master WE
m_adr_i  in  N_MASTER*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
m_dat_i  in  N_MASTER*DATA_W  packed write data
m_sel_i  in  N_MASTER*DATA_W/8  packed byte selects
m_dat_o  out  DATA_W  read data, broadcast to all masters
m_ack_o  out  N_MASTER  per-master ACK
m_err_o  out  N_MASTER  per-master ERR
s_cyc_o / s_stb_o / s_we_o  out  1 each  slave control
s_adr_o  out  ADDR_W  slave address
s_dat_o  out  DATA_W  slave write data
s_sel_o  out  DATA_W/8  slave byte select
s_dat_i  in  DATA_W  slave read data
s_ack_i / s_err_i  in  1 each  slave response
grant_o  out  N_MASTER  one-hot current owner (debug/observability)

Behaviour:
- Clock and reset: one clock, clk. Reset rstn_i is asynchronous and active-low.
- Reset values: state=IDLE, grant=0, last=N_MASTER-1 (so master 0 wins first), timeout counter=0.
  - All s_* control outputs, m_ack_o, m_err_o and grant_o are 0.
  - m_dat_o follows s_dat_i.
  - Reset asserted mid-transfer drops s_cyc_o/s_stb_o asynchronously. No ACK is forwarded afterwards.
- IDLE:
  - If any m_cyc_i is high, pick the first requester searching from (last+1) mod N_MASTER upward with wrap-around.
  - Register it into grant and go to BUSY.
  - Grant latency is 1 cycle: s_cyc_o rises in the cycle after the winner's CYC is first sampled.
  - Nothing is driven to the slave while in IDLE.
- BUSY:
  - s_cyc/stb/we/adr/dat/sel are combinationally muxed from the granted master.
  - s_ack_i/s_err_i are routed only to the granted bit of m_ack_o/m_err_o. Non-owners always see 0.
  - Owner multi-beat bursts (several STBs within one CYC) keep the grant.
  - When the owner's m_cyc_i is low: s_cyc_o=0 that cycle, last<=owner, grant<=0, go to IDLE.
  - Re-arbitration therefore costs 1 idle cycle between owners.
- Timeout (TIMEOUT>0):
  - The counter increments each BUSY cycle with s_stb_o high and no s_ack_i/s_err_i.
  - It clears on ACK, ERR, or STB low.
  - When it reaches TIMEOUT, in that same cycle: pulse the owner's m_err_o for 1 cycle, force s_cyc_o=s_stb_o=0, go to ABORT.
- ABORT:
  - Slave outputs are 0; the owner receives no ACK/ERR.
  - Wait for the owner's m_cyc_i low, then last<=owner and go to IDLE.
  - A late s_ack_i arriving in ABORT is ignored.
- Simultaneous events:
  - ACK and timeout reached in the same cycle: ACK wins, the counter clears, stay in BUSY.
  - ACK and ERR together: both are forwarded unchanged.
  - Owner drops CYC in the same cycle as an ACK: the ACK is forwarded and the state still goes to IDLE.
- Masters that drop CYC while waiting are simply not considered; no request latching.
- Counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the counter logic is removed and ABORT is unreachable.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_state_e enum {IDLE, BUSY, ABORT};
  - a function returning the index of a one-hot vector;
  - the default width constants.
- One natural sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N], last index.
  - Outputs: one-hot grant, valid.
  - Unit-testable on its own.

Test Plan:
1. N=3, TIMEOUT=16. Master 1 reads 0x40, the slave ACKs after 2 cycles with 0xDEADBEEF -> s_cyc_o rises 1 cycle after m_cyc_i[1]; s_adr_o=0x40; m_ack_o=3'b010 with m_dat_o=0xDEADBEEF; grant_o=0 the cycle after CYC drops.
2. From reset, all three masters assert CYC, each doing 1 write and dropping CYC after its ACK -> grant order 001, 010, 100 with exactly 1 IDLE cycle between owners.
3. Master 0 holds CYC for a 4-beat burst (0x0,0x4,0x8,0xC) while master 2 requests -> 4 ACKs to master 0 only; m_ack_o[2] stays 0; master 2 is granted only after master 0 drops CYC.
4. The slave never ACKs master 1's read -> after 16 STB cycles m_err_o=3'b010 for 1 cycle, s_cyc_o=0, ABORT until master 1 drops CYC; a late ACK in ABORT produces no m_ack_o.
5. rstn_i pulsed low during master 2's pending transfer -> s_cyc_o=0 asynchronously; after release with masters 0 and 2 requesting, master 0 is granted first.
6. Fairness: master 0 finishes and re-asserts CYC in the very next cycle while master 1 is waiting -> master 1 is granted before master 0.
